instr_loader: RTL and testbench

- Writer-side counterpart to the instruction-fetch path.
- Receives a program as a byte stream over a valid/ready handshake and assembles each pair of bytes into one 9-bit instruction.
- Writes the instructions sequentially into the instruction memory write port, starting at a programmable base address.
- Holds the processor in start while loading, and reports completion, a framing error and a running XOR checksum.

---
 rtl/instr_loader_if.sv | 30 +++
 rtl/instr_loader.sv | 99 +++++++++
 tb/tb_instr_loader.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_loader_if.sv
// Loader control, byte-stream and instruction-memory write bundle.
// The master side is the host/testbench; the slave side is the loader.
interface instr_loader_if #(
  parameter int unsigned IW = 9,
  parameter int unsigned AW = 8
);
  logic          Go;
  logic [AW-1:0] BaseAddr;
  logic [AW:0]   Len;
  logic          InValid;
  logic [7:0]    InData;
  logic          InReady;
  logic          WrEn;
  logic [AW-1:0] WrAddr;
  logic [IW-1:0] WrData;
  logic          Busy;
  logic          Done;
  logic          Err;
  logic [IW-1:0] Checksum;

  modport master (
    output Go, BaseAddr, Len, InValid, InData,
    input  InReady, WrEn, WrAddr, WrData, Busy, Done, Err, Checksum
  );

  modport slave (
    input  Go, BaseAddr, Len, InValid, InData,
    output InReady, WrEn, WrAddr, WrData, Busy, Done, Err, Checksum
  );
endinterface

// File: rtl/instr_loader.sv
// Assembles byte pairs into IW-bit instructions and writes them sequentially
// into instruction memory, holding the processor in start while loading.
module instr_loader #(
  parameter int unsigned IW    = 9,
  parameter int unsigned AW    = 8,
  parameter int unsigned DEPTH = 256
) (
  input  logic         CLK,
  input  logic         Start,
  instr_loader_if.slave bus
);

  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, LO, HI, FIN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [CW-1:0] remaining_q;
  logic [7:0]    lo_q;
  logic          accept;
  logic [CW-1:0] len_clamped;
  logic [IW-1:0] word;

  // Requested length saturates at the memory depth; only bit 0 of the high byte is data.
  always_comb begin
    len_clamped = (bus.Len > CW'(DEPTH)) ? CW'(DEPTH) : bus.Len;
    word        = IW'({bus.InData[0], lo_q});
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: if (bus.Go) state_d = (len_clamped != '0) ? LO : FIN;
      LO: begin
        if (bus.InValid && bus.InReady) begin
          accept  = 1'b1;
          state_d = HI;
        end
      end
      HI: begin
        if (bus.InValid && bus.InReady) begin
          accept  = 1'b1;
          state_d = (remaining_q == CW'(1)) ? FIN : LO;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Start) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Handshake/status flags are registered from the next state so they track the FSM exactly.
  always_ff @(posedge CLK) begin
    if (Start) begin
      addr_q       <= '0;
      remaining_q  <= '0;
      lo_q         <= '0;
      bus.InReady  <= 1'b0;
      bus.Busy     <= 1'b0;
      bus.Done     <= 1'b0;
      bus.Err      <= 1'b0;
      bus.WrEn     <= 1'b0;
      bus.WrAddr   <= '0;
      bus.WrData   <= '0;
      bus.Checksum <= '0;
    end else begin
      bus.InReady <= (state_d == LO) || (state_d == HI);
      bus.Busy    <= (state_d != IDLE);
      bus.Done    <= (state_q == FIN);
      bus.WrEn    <= 1'b0;

      if (state_q == IDLE && bus.Go) begin
        addr_q       <= bus.BaseAddr;
        remaining_q  <= len_clamped;
        bus.Checksum <= '0;
        bus.Err      <= 1'b0;
      end

      if (state_q == LO && accept) lo_q <= bus.InData;

      if (state_q == HI && accept) begin
        bus.WrEn     <= 1'b1;
        bus.WrAddr   <= addr_q;
        bus.WrData   <= word;
        bus.Checksum <= bus.Checksum ^ word;
        addr_q       <= addr_q + AW'(1);
        remaining_q  <= remaining_q - CW'(1);
        if (bus.InData[7:1] != 7'd0) bus.Err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: scoreboard of expected memory writes,
// a table of single-instruction loads, and directed multi-cycle sequences.
module tb_instr_loader;

  localparam int unsigned IW = 9;
  localparam int unsigned AW = 8;

  logic CLK;
  logic Start;

  instr_loader_if #(.IW(IW), .AW(AW)) bus ();

  instr_loader #(.IW(IW), .AW(AW), .DEPTH(256)) dut (
    .CLK  (CLK),
    .Start(Start),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [IW-1:0] data;
  } wr_t;

  typedef struct {
    logic [7:0] base;
    logic [7:0] lo;
    logic [7:0] hi;
    logic [8:0] exp_data;
    logic       exp_err;
  } vec_t;

  wr_t           exp_q[$];
  int            checks = 0;
  int            passes = 0;
  int            wr_count = 0;
  logic [AW-1:0] model_addr;
  logic [IW-1:0] model_ck;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else passes++;
  endtask

  // Scoreboard consumer: every write strobe must match the oldest expected write.
  always @(negedge CLK) begin
    if (!Start && bus.WrEn) begin
      wr_t e;
      wr_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(bus.WrAddr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus.WrAddr), 32'(e.addr));
        check("wr_data", 32'(bus.WrData), 32'(e.data));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  task automatic go(input logic [7:0] base, input logic [8:0] len);
    bus.Go       = 1'b1;
    bus.BaseAddr = base;
    bus.Len      = len;
    model_addr   = base;
    model_ck     = '0;
    step();
    bus.Go = 1'b0;
  endtask

  // Offers one byte (after an optional idle gap) and returns just after the edge that took it.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc = 0;
    int n = 0;
    if (gap > 0) begin
      bus.InValid = 1'b0;
      repeat (gap) step();
    end
    bus.InValid = 1'b1;
    bus.InData  = b;
    do begin
      @(negedge CLK);
      acc = bus.InReady;
      step();
      n++;
    end while (!acc && n < 100);
    if (!acc) check("byte_timeout", 32'd0, 32'd1);
    bus.InValid = 1'b0;
  endtask

  task automatic send_instr(input logic [7:0] lo, input logic [7:0] hi, input int gap);
    wr_t e;
    e.addr = model_addr;
    e.data = {hi[0], lo};
    exp_q.push_back(e);
    model_addr = model_addr + 8'd1;
    model_ck   = model_ck ^ e.data;
    send_byte(lo, gap);
    send_byte(hi, gap);
  endtask

  // Called in the FIN cycle: checks the release handshake and final status.
  task automatic finish_check(input logic [8:0] exp_ck, input logic exp_err);
    check("fin_busy", 32'(bus.Busy), 32'd1);
    check("fin_ready", 32'(bus.InReady), 32'd0);
    check("fin_no_done", 32'(bus.Done), 32'd0);
    step();
    check("done_pulse", 32'(bus.Done), 32'd1);
    check("done_busy_low", 32'(bus.Busy), 32'd0);
    check("checksum", 32'(bus.Checksum), 32'(exp_ck));
    check("err", 32'(bus.Err), 32'(exp_err));
    step();
    check("done_once", 32'(bus.Done), 32'd0);
    check("err_sticky", 32'(bus.Err), 32'(exp_err));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(bus.InReady), 32'd0);
    check({tag, "_wren"}, 32'(bus.WrEn), 32'd0);
    check({tag, "_busy"}, 32'(bus.Busy), 32'd0);
    check({tag, "_done"}, 32'(bus.Done), 32'd0);
    check({tag, "_err"}, 32'(bus.Err), 32'd0);
    check({tag, "_waddr"}, 32'(bus.WrAddr), 32'd0);
    check({tag, "_wdata"}, 32'(bus.WrData), 32'd0);
    check({tag, "_cksum"}, 32'(bus.Checksum), 32'd0);
  endtask

  initial begin
    vec_t vecs[4];
    int   w0;

    vecs[0] = '{8'h40, 8'h12, 8'h83, 9'h112, 1'b1};
    vecs[1] = '{8'h41, 8'hFF, 8'h01, 9'h1FF, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 8'hFE, 9'h000, 1'b1};
    vecs[3] = '{8'h80, 8'h5A, 8'h00, 9'h05A, 1'b0};

    Start = 1'b1;
    bus.Go = 1'b0; bus.BaseAddr = '0; bus.Len = '0;
    bus.InValid = 1'b0; bus.InData = '0;
    model_addr = '0; model_ck = '0;
    repeat (2) step();
    do_reset();
    check_all_zero("reset");

    // Basic back-to-back load
    go(8'h10, 9'd2);
    check("go_busy", 32'(bus.Busy), 32'd1);
    check("go_ready", 32'(bus.InReady), 32'd1);
    send_instr(8'hA5, 8'h01, 0);
    send_instr(8'h3C, 8'h00, 0);
    finish_check(9'h199, 1'b0);

    // Wrap at top of memory with InValid toggling
    w0 = wr_count;
    go(8'hFF, 9'd2);
    send_instr(8'h6E, 8'h01, 1);
    send_instr(8'h91, 8'h00, 1);
    finish_check(9'h1FF, 1'b0);
    check("wrap_wr_count", 32'(wr_count - w0), 32'd2);

    // Table of single-instruction loads; Go must clear the prior sticky Err
    for (int i = 0; i < 4; i++) begin
      go(vecs[i].base, 9'd1);
      check("go_clears_err", 32'(bus.Err), 32'd0);
      check("go_clears_cksum", 32'(bus.Checksum), 32'd0);
      send_instr(vecs[i].lo, vecs[i].hi, 0);
      finish_check(vecs[i].exp_data, vecs[i].exp_err);
      step();
      check("err_idle_hold", 32'(bus.Err), 32'(vecs[i].exp_err));
    end

    // Len=0 with InValid held high through IDLE and FIN
    w0 = wr_count;
    bus.InValid = 1'b1; bus.InData = 8'h77;
    go(8'h20, 9'd0);
    check("len0_ready", 32'(bus.InReady), 32'd0);
    check("len0_busy", 32'(bus.Busy), 32'd1);
    check("len0_no_done", 32'(bus.Done), 32'd0);
    step();
    check("len0_done", 32'(bus.Done), 32'd1);
    check("len0_busy_low", 32'(bus.Busy), 32'd0);
    step();
    check("len0_done_once", 32'(bus.Done), 32'd0);
    check("len0_no_writes", 32'(wr_count - w0), 32'd0);
    bus.InValid = 1'b0;

    // Go with a byte already valid: that IDLE byte must not be taken as the low byte
    bus.InValid = 1'b1; bus.InData = 8'h33;
    go(8'h70, 9'd1);
    send_instr(8'h44, 8'h01, 0);
    finish_check(9'h144, 1'b0);

    // Len above depth clamps to 256 writes, ending one below the base
    w0 = wr_count;
    go(8'h37, 9'd300);
    for (int i = 0; i < 256; i++)
      send_instr(8'($urandom_range(0, 255)), 8'($urandom_range(0, 1)), 0);
    finish_check(model_ck, 1'b0);
    check("clamp_wr_count", 32'(wr_count - w0), 32'd256);
    check("clamp_last_addr", 32'(bus.WrAddr), 32'h36);

    // Reset in HI after three of five instructions
    go(8'h50, 9'd5);
    for (int i = 0; i < 3; i++) send_instr(8'(8'h20 + i), 8'h01, 0);
    send_byte(8'hEE, 0);
    check("pre_reset_busy", 32'(bus.Busy), 32'd1);
    do_reset();
    check_all_zero("midreset");
    step();
    check("midreset_no_done", 32'(bus.Done), 32'd0);
    go(8'h60, 9'd1);
    send_instr(8'hC3, 8'h00, 0);
    finish_check(9'h0C3, 1'b0);

    // Go pulsed while in LO is ignored
    go(8'h90, 9'd2);
    bus.Go = 1'b1; bus.BaseAddr = 8'h00; bus.Len = 9'd0;
    step();
    bus.Go = 1'b0;
    check("lo_go_ignored", 32'(bus.InReady), 32'd1);
    send_instr(8'h01, 8'h01, 0);
    send_instr(8'h02, 8'h00, 0);
    finish_check(9'h103, 1'b0);

    repeat (3) step();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
